// File: rtl/add_accum_pkg.sv
// Shared definitions for the pipelined adder/accumulator: op encodings and
// the all-ones saturation constant helper.
package add_accum_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ACC  = 2'b01,
        OP_CLR  = 2'b10,
        OP_SADD = 2'b11
    } op_e;

    localparam int SAT_MAX_W = 64;

    // All-ones value of width w, returned right-aligned in a 64-bit word.
    function automatic logic [SAT_MAX_W-1:0] sat_const(input int w);
        logic [SAT_MAX_W-1:0] ones;
        ones = '1;
        if (w >= SAT_MAX_W)
            sat_const = ones;
        else
            sat_const = ones >> (SAT_MAX_W - w);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready register slice with a parametrised payload.
// Ready is combinational from downstream so a full chain advances without bubbles.
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Payload is only sampled when the slice is free to move and the beat is real.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/add_accum_pipe.sv
// Two-stage pipelined adder/accumulator with valid/ready on both sides,
// wrap or saturate accumulator policy and a sticky overflow flag.
module add_accum_pipe
    import add_accum_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int SATURATE  = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 ovf,
    output logic [CNT_WIDTH-1:0] acc_cnt
);

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_payload_t;

    localparam int                   S1_W    = $bits(s1_payload_t);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_const(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] OPR_MAX = ACC_WIDTH'(sat_const(WIDTH));

    s1_payload_t          s1_in;
    s1_payload_t          s1_data;
    logic [S1_W-1:0]      s1_bits;
    logic                 s1_valid;
    logic                 s2_rdy;
    logic                 s1_fire;

    logic [ACC_WIDTH-1:0] acc;
    logic [WIDTH:0]       sum_ab;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 acc_ovf;
    logic [ACC_WIDTH-1:0] acc_new;
    logic [ACC_WIDTH-1:0] res_next;

    assign s1_in = '{op: op_e'(op), a: a, b: b};

    pipe_stage_reg #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_rdy),
        .out_data  (s1_bits)
    );

    assign s1_data = s1_payload_t'(s1_bits);
    assign s1_fire = s1_valid && s2_rdy;

    // Accumulate is evaluated against the live acc so back-to-back ACC beats chain.
    always_comb begin
        sum_ab   = {1'b0, s1_data.a} + {1'b0, s1_data.b};
        acc_sum  = {1'b0, acc} + (ACC_WIDTH + 1)'(sum_ab);
        acc_ovf  = acc_sum[ACC_WIDTH];
        acc_new  = acc_sum[ACC_WIDTH-1:0];
        if (acc_ovf && (SATURATE != 0))
            acc_new = ACC_MAX;
        res_next = '0;
        case (s1_data.op)
            OP_ADD:  res_next = ACC_WIDTH'(sum_ab);
            OP_ACC:  res_next = acc_new;
            OP_CLR:  res_next = '0;
            OP_SADD: res_next = sum_ab[WIDTH] ? OPR_MAX : ACC_WIDTH'(sum_ab);
            default: res_next = '0;
        endcase
    end

    pipe_stage_reg #(.W(ACC_WIDTH)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_rdy),
        .in_data   (res_next),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (result)
    );

    // Architectural state commits only as a beat moves from s1 into s2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            ovf     <= 1'b0;
            acc_cnt <= '0;
        end else if (s1_fire) begin
            case (s1_data.op)
                OP_ACC: begin
                    acc     <= acc_new;
                    acc_cnt <= acc_cnt + CNT_WIDTH'(1);
                    if (acc_ovf)
                        ovf <= 1'b1;
                end
                OP_CLR: begin
                    acc     <= '0;
                    ovf     <= 1'b0;
                    acc_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
